// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the CPU/DMA SRAM arbiter.
package ram_arb_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned RD_LATENCY = 2;
    localparam int unsigned WR_LATENCY = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WS,
        WL,
        WH,
        ACK
    } state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } ram_cmd_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and SRAM signal bundle; slave side is the arbiter, master side the requesters/SRAM.
interface ram_arbiter_if;
    import ram_arb_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_ack;
    logic [DATA_W-1:0] dma_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              _ram_oe;
    logic              _ram_we;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  ram_rdata,
        output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        output ram_addr, ram_wdata, _ram_oe, _ram_we, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output ram_rdata,
        input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        input  ram_addr, ram_wdata, _ram_oe, _ram_we, busy
    );

endinterface

// File: rtl/ram_arb_starve.sv
// Counts CPU grants made while DMA waits; forces a DMA win once the count reaches STARVE_LIMIT.
module ram_arb_starve
    import ram_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    grant,
    input  req_id_t grant_id,
    input  logic    dma_req,
    output logic    force_dma_c
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] count;

    assign force_dma_c = (count == CNT_W'(STARVE_LIMIT));

    // Saturates at the limit; the forced DMA grant that follows clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (grant) begin
            if (grant_id == REQ_DMA) begin
                count <= '0;
            end else if (dma_req && !force_dma_c) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester (CPU/DMA) arbiter sequencing an asynchronous SRAM with registered strobes.
// Define RAM_ARB_ROUND_ROBIN_EN for alternating arbitration instead of CPU priority + starvation guard.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    ram_arbiter_if.slave bus
);

    state_t   state;
    state_t   state_next;
    req_id_t  id;
    req_id_t  win_c;
    logic     grant_c;
    ram_cmd_t cpu_cmd_c;
    ram_cmd_t dma_cmd_c;
    ram_cmd_t sel_cmd_c;
    logic     oe_next;
    logic     we_next;
    logic     busy_next;
    logic     cpu_ack_next;
    logic     dma_ack_next;

    assign cpu_cmd_c = {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata};
    assign dma_cmd_c = {bus.dma_we, bus.dma_addr, bus.dma_wdata};

`ifdef RAM_ARB_ROUND_ROBIN_EN
    req_id_t last;

    // On a tie the requester that was not served last goes next.
    always_comb begin
        if (bus.cpu_req && bus.dma_req) begin
            win_c = (last == REQ_CPU) ? REQ_DMA : REQ_CPU;
        end else begin
            win_c = bus.dma_req ? REQ_DMA : REQ_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last <= REQ_DMA;
        end else if (grant_c) begin
            last <= win_c;
        end
    end
`else
    logic force_dma_c;

    ram_arb_starve #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .grant      (grant_c),
        .grant_id   (win_c),
        .dma_req    (bus.dma_req),
        .force_dma_c(force_dma_c)
    );

    always_comb begin
        win_c = (bus.dma_req && (!bus.cpu_req || force_dma_c)) ? REQ_DMA : REQ_CPU;
    end
`endif

    // Next state plus the next values of every registered SRAM/handshake output.
    always_comb begin
        state_next = state;
        grant_c    = 1'b0;
        sel_cmd_c  = (win_c == REQ_DMA) ? dma_cmd_c : cpu_cmd_c;
        case (state)
            IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    grant_c    = 1'b1;
                    state_next = sel_cmd_c.we ? WS : RD;
                end
            end
            RD:      state_next = ACK;
            WS:      state_next = WL;
            WL:      state_next = WH;
            WH:      state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        oe_next      = (state_next != RD);
        we_next      = (state_next != WL);
        busy_next    = (state_next != IDLE);
        cpu_ack_next = (state_next == ACK) && (id == REQ_CPU);
        dma_ack_next = (state_next == ACK) && (id == REQ_DMA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id            <= REQ_CPU;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus._ram_oe   <= 1'b1;
            bus._ram_we   <= 1'b1;
            bus.busy      <= 1'b0;
            bus.cpu_ack   <= 1'b0;
            bus.dma_ack   <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.dma_rdata <= '0;
        end else begin
            bus._ram_oe <= oe_next;
            bus._ram_we <= we_next;
            bus.busy    <= busy_next;
            bus.cpu_ack <= cpu_ack_next;
            bus.dma_ack <= dma_ack_next;
            if (grant_c) begin
                id            <= win_c;
                bus.ram_addr  <= sel_cmd_c.addr;
                bus.ram_wdata <= sel_cmd_c.wdata;
            end
            // Read data is sampled at the end of the single output-enable cycle.
            if (state == RD) begin
                if (id == REQ_CPU) begin
                    bus.cpu_rdata <= bus.ram_rdata;
                end else begin
                    bus.dma_rdata <= bus.ram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural SRAM model.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   passed = 0;
    int   viol = 0;

    ram_arbiter_if bus();

    ram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // SRAM model: write commits on a clock edge while the strobe is low; read is combinational.
    logic [7:0] mem [0:65535];
    always @(posedge clk) if (bus._ram_we === 1'b0) mem[bus.ram_addr] <= bus.ram_wdata;
    assign bus.ram_rdata = (bus._ram_oe === 1'b0) ? mem[bus.ram_addr] : 8'h00;

    // Cycle monitor: strobe overlap, simultaneous acks, acks longer than one cycle.
    logic prev_cpu_ack = 1'b0;
    logic prev_dma_ack = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus._ram_oe === 1'b0 && bus._ram_we === 1'b0) begin
                viol++; $display("protocol violation at %0t: oe and we both low", $time);
            end
            if (bus.cpu_ack === 1'b1 && bus.dma_ack === 1'b1) begin
                viol++; $display("protocol violation at %0t: both acks high", $time);
            end
            if ((bus.cpu_ack && prev_cpu_ack) || (bus.dma_ack && prev_dma_ack)) begin
                viol++; $display("protocol violation at %0t: ack longer than one cycle", $time);
            end
        end
        prev_cpu_ack = bus.cpu_ack;
        prev_dma_ack = bus.dma_ack;
    end

    typedef struct {
        req_id_t     who;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        bit          drop;
        logic [7:0]  exp_cpu_rdata;
        logic [7:0]  exp_dma_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic release_req(input req_id_t who);
        if (who == REQ_CPU) bus.cpu_req = 1'b0;
        else bus.dma_req = 1'b0;
    endtask

    task automatic apply_reset();
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One transaction: latency in cycles to ack, strobe-cycle count and address seen during the strobe.
    task automatic do_xact(input req_id_t who, input logic we, input logic [15:0] addr,
                           input logic [7:0] wdata, input bit drop,
                           output int lat, output int strobes, output logic [15:0] saddr);
        lat = -1;
        strobes = 0;
        saddr = 16'h0;
        if (who == REQ_CPU) begin
            bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
        end else begin
            bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata; bus.dma_req = 1'b1;
        end
        for (int c = 1; c <= 20; c++) begin
            tick();
            if ((we ? bus._ram_we : bus._ram_oe) == 1'b0) begin
                strobes++;
                saddr = bus.ram_addr;
            end
            if (drop && c == 1) release_req(who);
            if ((who == REQ_CPU ? bus.dma_ack : bus.cpu_ack) == 1'b1) viol++;
            if ((who == REQ_CPU ? bus.cpu_ack : bus.dma_ack) == 1'b1) begin
                lat = c;
                break;
            end
        end
        release_req(who);
        tick();
    endtask

    initial begin
        int          lat;
        int          strobes;
        logic [15:0] saddr;
        int          order[10];
        int          exp_order[10];
        int          n;
        int          seen;

        vecs[0]  = '{REQ_CPU, 1'b1, 16'h0101, 8'h55, 1'b0, 8'h00, 8'h00, WR_LATENCY};
        vecs[1]  = '{REQ_CPU, 1'b0, 16'h0101, 8'h00, 1'b0, 8'h55, 8'h00, RD_LATENCY};
        vecs[2]  = '{REQ_DMA, 1'b1, 16'h0000, 8'h3C, 1'b0, 8'h55, 8'h00, WR_LATENCY};
        vecs[3]  = '{REQ_DMA, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h55, 8'h3C, RD_LATENCY};
        vecs[4]  = '{REQ_CPU, 1'b1, 16'hFFFF, 8'h81, 1'b0, 8'h55, 8'h3C, WR_LATENCY};
        vecs[5]  = '{REQ_CPU, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h3C, 8'h3C, RD_LATENCY};
        vecs[6]  = '{REQ_DMA, 1'b0, 16'hFFFF, 8'h00, 1'b0, 8'h3C, 8'h81, RD_LATENCY};
        vecs[7]  = '{REQ_CPU, 1'b0, 16'h0101, 8'h00, 1'b0, 8'h55, 8'h81, RD_LATENCY};
        vecs[8]  = '{REQ_DMA, 1'b1, 16'h8000, 8'hA5, 1'b0, 8'h55, 8'h81, WR_LATENCY};
        vecs[9]  = '{REQ_CPU, 1'b0, 16'h8000, 8'h00, 1'b0, 8'hA5, 8'h81, RD_LATENCY};
        vecs[10] = '{REQ_DMA, 1'b1, 16'hFFFF, 8'hAA, 1'b1, 8'hA5, 8'h81, WR_LATENCY};
        vecs[11] = '{REQ_CPU, 1'b0, 16'hFFFF, 8'h00, 1'b0, 8'hAA, 8'h81, RD_LATENCY};

        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_wdata = 8'h0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 16'h0; bus.dma_wdata = 8'h0;

        tick();
        check("rst_oe",        32'(bus._ram_oe),   32'd1);
        check("rst_we",        32'(bus._ram_we),   32'd1);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_cpu_ack",   32'(bus.cpu_ack),   32'd0);
        check("rst_dma_ack",   32'(bus.dma_ack),   32'd0);
        check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        check("rst_dma_rdata", 32'(bus.dma_rdata), 32'd0);
        check("rst_ram_addr",  32'(bus.ram_addr),  32'd0);
        check("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_xact(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].drop,
                    lat, strobes, saddr);
            check($sformatf("v%0d_latency", i),   32'(lat),           32'(vecs[i].exp_lat));
            check($sformatf("v%0d_strobes", i),   32'(strobes),       32'd1);
            check($sformatf("v%0d_strobe_addr", i), 32'(saddr),       32'(vecs[i].addr));
            check($sformatf("v%0d_cpu_rdata", i), 32'(bus.cpu_rdata), 32'(vecs[i].exp_cpu_rdata));
            check($sformatf("v%0d_dma_rdata", i), 32'(bus.dma_rdata), 32'(vecs[i].exp_dma_rdata));
        end

        // Both requesters held high: record the grant order from the ack pulses.
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            order[i] = 3;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            exp_order[i] = i % 2;
`else
            exp_order[i] = (i % 5 == 4) ? 1 : 0;
`endif
        end
        bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0101;
        bus.dma_we = 1'b0; bus.dma_addr = 16'h0000;
        bus.cpu_req = 1'b1;
        bus.dma_req = 1'b1;
        n = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            tick();
            if (bus.cpu_ack) begin order[n] = 0; n++; end
            else if (bus.dma_ack) begin order[n] = 1; n++; end
        end
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 10; i++) check($sformatf("grant_order_%0d", i), 32'(order[i]), 32'(exp_order[i]));

        // Reset during the strobe-low cycle of a write aborts it without an ack.
        do_xact(REQ_CPU, 1'b1, 16'h0202, 8'h77, 1'b0, lat, strobes, saddr);
        check("prewrite_latency", 32'(lat), 32'd4);
        bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0202; bus.cpu_wdata = 8'h77; bus.cpu_req = 1'b1;
        tick();
        check("abort_ws_busy", 32'(bus.busy),    32'd1);
        check("abort_ws_we",   32'(bus._ram_we), 32'd1);
        tick();
        check("abort_wl_we",   32'(bus._ram_we), 32'd0);
        reset = 1'b1;
        tick();
        check("abort_rst_we",   32'(bus._ram_we), 32'd1);
        check("abort_rst_busy", 32'(bus.busy),    32'd0);
        check("abort_rst_ack",  32'(bus.cpu_ack), 32'd0);
        bus.cpu_req = 1'b0;
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.cpu_ack || bus.dma_ack) seen++;
        end
        check("abort_no_ack", 32'(seen), 32'd0);
        do_xact(REQ_CPU, 1'b0, 16'h0202, 8'h00, 1'b0, lat, strobes, saddr);
        check("post_abort_latency", 32'(lat),           32'd2);
        check("post_abort_rdata",   32'(bus.cpu_rdata), 32'h77);

        check("protocol_violations", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, sets the number of consecutive CPU grants allowed while dma_req is pending.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 cpu_req  input  1  CPU access request; held high until cpu_ack.
REQ-005 cpu_we  input  1  1 = write, 0 = read; sampled at grant.
REQ-006 cpu_addr  input  16  CPU address ({MARHI, MARLO}).
REQ-007 cpu_wdata  input  8  CPU write data.
REQ-008 cpu_ack  output  1  one-cycle completion pulse to the CPU.
REQ-009 cpu_rdata  output  8  registered read data for the CPU; held until the next CPU read completes.
REQ-010 dma_req, dma_we, dma_addr[15:0], dma_wdata[7:0], dma_ack, dma_rdata[7:0]: same directions and meanings as the CPU port, for the DMA/loader requester.
REQ-011 ram_addr  output  16  registered SRAM address.
REQ-012 ram_wdata  output  8  registered SRAM write data.
REQ-013 ram_rdata  input  8  SRAM read data.
REQ-014 _ram_oe  output  1  SRAM output enable, active-low.
REQ-015 _ram_we  output  1  SRAM write strobe, active-low.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, RD, WS (write setup), WL (strobe low), WH (write hold), ACK.
REQ-018 IDLE: if any request is high, latch the winner's addr, wdata, we and id; go to RD (we=0) or WS (we=1). Otherwise stay in IDLE.
REQ-019 RD: _ram_oe=0; at the cycle end, capture ram_rdata into the winner's rdata register; go to ACK.
REQ-020 WS: _ram_we=1, with addr and data driven. WL: _ram_we=0. WH: _ram_we=1, with addr and data still held. Then go to ACK.
REQ-021 ACK: pulse the winner's ack for exactly one cycle; ignore all requests; go to IDLE.
REQ-022 Latency: with req first high in cycle N and the arbiter in IDLE, a read acks in cycle N+2 and a write acks in cycle N+4.
REQ-023 _ram_oe and _ram_we are never low in the same cycle; _ram_oe is high outside RD.
REQ-024 Default priority: CPU wins over DMA when both requests are high.
REQ-025 Starvation count: increments on each CPU grant made while dma_req is high. When the count equals STARVE_LIMIT, DMA wins the next arbitration. The count clears on every DMA grant.
REQ-026 A requester that deasserts req mid-transaction does not abort the transaction; it completes and ack is still pulsed.
REQ-027 Address is used full 16-bit; no wrap or modification, so 0xFFFF is a valid address.
REQ-028 Only the granted requester's ack or rdata changes; the other port's outputs hold.

Reset
REQ-029 On a clock edge with reset=1: state=IDLE, _ram_oe=1, _ram_we=1, cpu_ack=dma_ack=0, cpu_rdata=dma_rdata=0, ram_addr=0, ram_wdata=0, busy=0, starvation count=0, last-granted=DMA.
REQ-030 Reset asserted mid-write: _ram_we is high from the first reset edge. No ack is issued for the aborted transaction.

Configuration
REQ-031 Macro RAM_ARB_ROUND_ROBIN_EN.
- Defined: arbitration alternates, and the requester not granted last wins a tie. The starvation counter and STARVE_LIMIT logic are not compiled in.
- Undefined: fixed CPU priority with the starvation counter (REQ-024/025).

Structure
REQ-032 Package ram_arb_pkg holds the state enum, the requester-id typedef (REQ_CPU, REQ_DMA) and the timing constants RD_LATENCY=2 and WR_LATENCY=4.
REQ-033 One sub-module, ram_arb_starve, holds the starvation counter and the DMA-force output; it is instantiated only when RAM_ARB_ROUND_ROBIN_EN is undefined.

Verification
REQ-034 CPU write 0x55 to 0x0101, then a CPU read of 0x0101 -> write ack at N+4; exactly one _ram_we low cycle with ram_addr=0x0101; read ack at N+2; cpu_rdata=0x55.
REQ-035 cpu_req and dma_req held continuously high, STARVE_LIMIT=4 -> grant order CPU, CPU, CPU, CPU, DMA, repeating. With RAM_ARB_ROUND_ROBIN_EN defined -> order CPU, DMA, CPU, DMA.
REQ-036 reset raised during WL -> _ram_we=1 and busy=0 after that edge; no ack; next CPU read of the same address behaves normally.
REQ-037 DMA write 0xAA to 0xFFFF, with dma_req dropped during WS -> write completes; dma_ack pulses once; a CPU read of 0xFFFF returns 0xAA.
REQ-038 Every cycle, across all scenarios -> never _ram_oe=0 together with _ram_we=0; each ack is high for at most one consecutive cycle.
